gen_sequencer: RTL and testbench

Generation sequencer for the double-buffered life datapath; sits directly upstream of life_logic, gating its start, and alongside the renderer.
- Counts video frames against the user speed setting and issues one start pulse per generation to life_logic.
- Waits for the generation to finish, then flips the front/back buffer select only during vertical sync, with the renderer idle, so no frame tears.
- Drives the status signals shown on LEDs.

---
 rtl/gen_sequencer_pkg.sv | 19 +
 rtl/gen_sequencer_edge_detect.sv | 33 +++
 rtl/gen_sequencer.sv | 138 +++++++++++++
 tb/tb_gen_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_sequencer_pkg.sv
// Shared types for the generation sequencer: default widths, data types and FSM states.
package gen_sequencer_pkg;

  localparam int SPEED_W_DEF    = 4;
  localparam int GEN_W_DEF      = 16;
  localparam int WDT_CYCLES_DEF = 2 ** 20;

  typedef logic [SPEED_W_DEF-1:0] speed_t;
  typedef logic [GEN_W_DEF-1:0]   gen_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    COMPUTE,
    PEND_SWAP,
    SWAP
  } seq_state_t;

endpackage

// File: rtl/gen_sequencer_edge_detect.sv
// Registered single-cycle edge pulse; FALLING selects falling (1) or rising (0) edge.
module gen_sequencer_edge_detect #(
  parameter bit FALLING = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic pulse_out
);

  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    prev_d  = sig_in;
    pulse_d = FALLING ? (prev_q & ~sig_in) : (~prev_q & sig_in);
  end

  // Previous sample starts at the idle level so reset release never looks like an edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prev_q  <= FALLING;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/gen_sequencer.sv
// Paces life_logic generations by frame count and flips the front buffer only on a clean vsync.
// Optional compute watchdog enabled by defining GEN_SEQ_WATCHDOG_EN.
module gen_sequencer
  import gen_sequencer_pkg::*;
#(
  parameter int SPEED_W    = SPEED_W_DEF,
  parameter int GEN_W      = GEN_W_DEF,
  parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               vsync_in,
  input  logic [SPEED_W-1:0] speed_in,
  input  logic               step_in,
  input  logic               logic_done_in,
  input  logic               render_done_in,
  output logic               logic_start_out,
  output logic               buf_swap_out,
  output logic               db_ready_out,
  output logic               busy_out,
  output logic [GEN_W-1:0]   gen_count_out,
  output logic               timeout_out
);

  localparam logic [SPEED_W:0] PERIOD_FULL = (SPEED_W+1)'(2 ** SPEED_W);

  seq_state_t         state_q, state_d;
  logic [SPEED_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               buf_swap_q, buf_swap_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               frame_tick;
  logic               wdt_expired;
  logic [SPEED_W:0]   period;
  logic [SPEED_W:0]   frame_inc;

  gen_sequencer_edge_detect #(.FALLING(1'b1)) u_vsync_edge (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .sig_in    (vsync_in),
    .pulse_out (frame_tick)
  );

  assign period    = PERIOD_FULL - {1'b0, speed_in};
  assign frame_inc = {1'b0, frame_cnt_q} + (SPEED_W+1)'(1);

`ifdef GEN_SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    wdt_d     = '0;
    timeout_d = timeout_q | wdt_expired;
    if (state_q == COMPUTE) wdt_d = wdt_q + WDT_W'(1);
  end

  assign wdt_expired = (state_q == COMPUTE) && !logic_done_in &&
                       (wdt_q == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_out = timeout_q;
`else
  wire unused_wdt = (WDT_CYCLES != 0);

  assign wdt_expired = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    buf_swap_d  = buf_swap_q;
    gen_d       = gen_q;
    case (state_q)
      IDLE: begin
        if (speed_in == '0) begin
          if (step_in) state_d = START;
        end else if (frame_tick) begin
          // >= so a period lowered mid-count fires on the very next tick.
          if (frame_inc >= period) begin
            frame_cnt_d = '0;
            state_d     = START;
          end else begin
            frame_cnt_d = frame_inc[SPEED_W-1:0];
          end
        end
      end
      // done during START belongs to the previous generation and is ignored.
      START:   state_d = COMPUTE;
      COMPUTE: begin
        if (logic_done_in)    state_d = PEND_SWAP;
        else if (wdt_expired) state_d = IDLE;
      end
      PEND_SWAP: begin
        if (frame_tick && render_done_in) state_d = SWAP;
      end
      SWAP: begin
        buf_swap_d  = ~buf_swap_q;
        gen_d       = gen_q + GEN_W'(1);
        frame_cnt_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      buf_swap_q  <= 1'b0;
      gen_q       <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      buf_swap_q  <= buf_swap_d;
      gen_q       <= gen_d;
    end
  end

  assign logic_start_out = (state_q == START);
  assign busy_out        = (state_q != IDLE);
  assign db_ready_out    = (state_q == PEND_SWAP) || (state_q == SWAP);
  assign buf_swap_out    = buf_swap_q;
  assign gen_count_out   = gen_q;

endmodule

// File: tb/tb_gen_sequencer.sv
// Scoreboard bench for gen_sequencer: expected swaps are queued at stimulus time and popped on each buffer flip.
module tb_gen_sequencer;

  localparam int SPEED_W  = 4;
  localparam int GEN_W    = 16;
  localparam int WDT      = 64;
  localparam int FRAME_HI = 30;

  logic               clk_in;
  logic               rst_in;
  logic               vsync_in;
  logic [SPEED_W-1:0] speed_in;
  logic               step_in;
  logic               logic_done_in;
  logic               render_done_in;
  logic               logic_start_out;
  logic               buf_swap_out;
  logic               db_ready_out;
  logic               busy_out;
  logic [GEN_W-1:0]   gen_count_out;
  logic               timeout_out;

  gen_sequencer #(
    .SPEED_W    (SPEED_W),
    .GEN_W      (GEN_W),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .vsync_in        (vsync_in),
    .speed_in        (speed_in),
    .step_in         (step_in),
    .logic_done_in   (logic_done_in),
    .render_done_in  (render_done_in),
    .logic_start_out (logic_start_out),
    .buf_swap_out    (buf_swap_out),
    .db_ready_out    (db_ready_out),
    .busy_out        (busy_out),
    .gen_count_out   (gen_count_out),
    .timeout_out     (timeout_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic             sel;
    logic [GEN_W-1:0] gen;
  } swap_t;

  swap_t            exp_q[$];
  int               n_cmp;
  int               n_mis;
  int               starts;
  logic             exp_sel;
  logic [GEN_W-1:0] exp_gen;
  bit               done_en;
  int               done_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic expect_swap();
    exp_sel = ~exp_sel;
    exp_gen = exp_gen + GEN_W'(1);
    exp_q.push_back('{sel: exp_sel, gen: exp_gen});
  endtask

  task automatic frame();
    @(negedge clk_in) vsync_in = 1'b0;
    repeat (2) @(negedge clk_in);
    vsync_in = 1'b1;
    repeat (FRAME_HI) @(negedge clk_in);
  endtask

  task automatic step_pulse();
    @(negedge clk_in) step_in = 1'b1;
    @(negedge clk_in) step_in = 1'b0;
  endtask

  // Counts start pulses and pops the scoreboard whenever the front buffer flips.
  initial begin
    logic  prev_sel;
    swap_t e;
    prev_sel = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        prev_sel = 1'b0;
      end else begin
        if (logic_start_out) starts++;
        if (buf_swap_out !== prev_sel) begin
          prev_sel = buf_swap_out;
          check("swap_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("swap_sel", buf_swap_out, e.sel);
            check("swap_gen", gen_count_out, e.gen);
          end
        end
      end
    end
  end

  // life_logic stand-in: pulses done a fixed delay after each start.
  initial begin
    logic_done_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (logic_start_out && done_en) begin
        repeat (done_delay) @(negedge clk_in);
        logic_done_in = 1'b1;
        @(negedge clk_in);
        logic_done_in = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_mis = 0; starts = 0;
    rst_in = 1'b0; vsync_in = 1'b1; speed_in = '0; step_in = 1'b0;
    render_done_in = 1'b1; done_en = 1'b1; done_delay = 10;
    exp_sel = 1'b0; exp_gen = '0;

    repeat (3) @(negedge clk_in);
    check("rst_start", logic_start_out, 0);
    check("rst_swap", buf_swap_out, 0);
    check("rst_db_ready", db_ready_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_gen", gen_count_out, 0);
    check("rst_timeout", timeout_out, 0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Speed 15: start on first vsync fall, swap on the second.
    speed_in = 4'd15; starts = 0;
    frame();
    check("s15_starts", starts, 1);
    check("s15_db_ready", db_ready_out, 1);
    check("s15_gen_pre", gen_count_out, 0);
    expect_swap();
    frame();
    check("s15_swap", buf_swap_out, 1);
    check("s15_gen", gen_count_out, 1);
    check("s15_busy", busy_out, 0);
    check("s15_queue", exp_q.size(), 0);

    // Speed 12 (period 4): swap tick is not counted, so starts land on ticks 4,9,14,19,24.
    speed_in = 4'd12; starts = 0;
    repeat (3) frame();
    check("s12_starts_3", starts, 0);
    frame();
    check("s12_starts_4", starts, 1);
    repeat (5) expect_swap();
    repeat (21) frame();
    check("s12_starts_25", starts, 5);
    check("s12_gen", gen_count_out, 6);
    check("s12_queue", exp_q.size(), 0);

    // Paused: no starts; one step gives one generation; step during COMPUTE ignored.
    speed_in = '0; starts = 0;
    repeat (10) frame();
    check("pause_starts", starts, 0);
    check("pause_gen", gen_count_out, 6);
    expect_swap();
    step_pulse();
    repeat (4) @(negedge clk_in);
    check("step_busy", busy_out, 1);
    step_pulse();
    repeat (10) @(negedge clk_in);
    frame();
    frame();
    check("step_starts", starts, 1);
    check("step_gen", gen_count_out, 7);
    check("step_queue", exp_q.size(), 0);

    // Renderer not done for two ticks: swap held until the third tick after done.
    render_done_in = 1'b0; speed_in = 4'd15;
    frame();
    frame();
    check("rend_db_ready_1", db_ready_out, 1);
    frame();
    check("rend_db_ready_2", db_ready_out, 1);
    check("rend_gen_held", gen_count_out, 7);
    render_done_in = 1'b1;
    expect_swap();
    frame();
    speed_in = '0;
    check("rend_db_ready_clr", db_ready_out, 0);
    check("rend_gen", gen_count_out, 8);
    check("rend_queue", exp_q.size(), 0);

    // Leave the front buffer at 1 so the reset clearing it is visible.
    expect_swap();
    step_pulse();
    repeat (15) @(negedge clk_in);
    frame();
    check("pre_rst_swap", buf_swap_out, 1);

    // Asynchronous reset mid-compute abandons the generation.
    starts = 0;
    step_pulse();
    repeat (3) @(negedge clk_in);
    check("midrst_busy", busy_out, 1);
    #2 rst_in = 1'b0;
    #1;
    check("midrst_start", logic_start_out, 0);
    check("midrst_busy0", busy_out, 0);
    check("midrst_db_ready", db_ready_out, 0);
    check("midrst_swap", buf_swap_out, 0);
    check("midrst_gen", gen_count_out, 0);
    exp_sel = 1'b0; exp_gen = '0;
    @(negedge clk_in) rst_in = 1'b1;
    starts = 0;
    repeat (20) @(negedge clk_in);
    frame();
    check("postrst_starts", starts, 0);
    check("postrst_swap", buf_swap_out, 0);
    check("postrst_gen", gen_count_out, 0);
    expect_swap();
    step_pulse();
    repeat (15) @(negedge clk_in);
    frame();
    check("postrst_gen1", gen_count_out, 1);
    check("postrst_swap1", buf_swap_out, 1);

`ifdef GEN_SEQ_WATCHDOG_EN
    // Compute never finishes: watchdog aborts after 64 COMPUTE cycles.
    done_en = 1'b0;
    step_pulse();
    repeat (63) @(negedge clk_in);
    check("wdt_busy_pre", busy_out, 1);
    check("wdt_timeout_pre", timeout_out, 0);
    repeat (2) @(negedge clk_in);
    check("wdt_busy", busy_out, 0);
    check("wdt_timeout", timeout_out, 1);
    check("wdt_gen", gen_count_out, 1);
    check("wdt_db_ready", db_ready_out, 0);
    done_en = 1'b1;
    expect_swap();
    step_pulse();
    repeat (15) @(negedge clk_in);
    frame();
    check("wdt_next_gen", gen_count_out, 2);
    check("wdt_sticky", timeout_out, 1);
`endif

    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
